// File: rtl/return_address_stack.sv
// Speculative return address stack for the fetch stage: pushes call return addresses,
// predicts return targets combinationally, and exposes a per-group recovery checkpoint.
module return_address_stack #(
  parameter int FETCH_WIDTH     = 2,
  parameter int RAS_ENTRY_NUM   = 16,
  parameter int PC_WIDTH        = 32,
  parameter int INSN_BYTE_WIDTH = 4,
  parameter int PTR_WIDTH       = $clog2(RAS_ENTRY_NUM),
  parameter int LANE_WIDTH      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetchValid,
  input  logic [PC_WIDTH-1:0]    fetchPC,
  input  logic [FETCH_WIDTH-1:0] laneValid,
  input  logic [FETCH_WIDTH-1:0] btbHit,
  input  logic [FETCH_WIDTH-1:0] isRASPushBr,
  input  logic [FETCH_WIDTH-1:0] isRASPopBr,
  output logic                   rasTargetValid,
  output logic [PC_WIDTH-1:0]    rasTarget,
  output logic [LANE_WIDTH-1:0]  rasLane,
  output logic [PTR_WIDTH-1:0]   checkpointPtr,
  output logic [PC_WIDTH-1:0]    checkpointTop,
  output logic [PTR_WIDTH:0]     checkpointCount,
  input  logic                   recoverValid,
  input  logic [PTR_WIDTH-1:0]   recoverPtr,
  input  logic [PC_WIDTH-1:0]    recoverTop,
  input  logic [PTR_WIDTH:0]     recoverCount,
  output logic [PTR_WIDTH:0]     depth
);

  localparam int CNT_WIDTH = PTR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(RAS_ENTRY_NUM);

  logic [PC_WIDTH-1:0]   entry_q [RAS_ENTRY_NUM];
  logic [PTR_WIDTH-1:0]  tos_q, tos_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;

  logic                  wr_en;
  logic [PTR_WIDTH-1:0]  wr_idx;
  logic [PC_WIDTH-1:0]   wr_data;

  logic                  lane_hit;
  logic [LANE_WIDTH-1:0] active_lane;
  logic                  do_push;
  logic                  do_pop;
  logic                  stack_empty;
  logic                  stack_full;
  logic [PTR_WIDTH-1:0]  tos_inc;
  logic [PTR_WIDTH-1:0]  tos_dec;
  logic [PC_WIDTH-1:0]   push_addr;

  logic [PTR_WIDTH-1:0]  upd_tos;
  logic [CNT_WIDTH-1:0]  upd_count;
  logic [PC_WIDTH-1:0]   upd_top;

  // A BTB hit is always taken, so the oldest hitting lane decides and younger lanes are dead.
  always_comb begin
    lane_hit    = 1'b0;
    active_lane = '0;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (fetchValid && laneValid[i] && btbHit[i]) begin
        lane_hit    = 1'b1;
        active_lane = LANE_WIDTH'(i);
      end
    end
  end

  assign stack_empty = (count_q == '0);
  assign stack_full  = (count_q == CNT_FULL);
  assign tos_inc     = tos_q + 1'b1;
  assign tos_dec     = tos_q - 1'b1;

  // A lane flagged as both call and return behaves as a call.
  assign do_push   = lane_hit && isRASPushBr[active_lane];
  assign do_pop    = lane_hit && isRASPopBr[active_lane] && !isRASPushBr[active_lane];
  assign push_addr = fetchPC + PC_WIDTH'((int'(active_lane) + 1) * INSN_BYTE_WIDTH);

  always_comb begin
    upd_tos   = tos_q;
    upd_count = count_q;
    upd_top   = entry_q[tos_q];
    if (do_push) begin
      upd_tos   = tos_inc;
      upd_top   = push_addr;
      upd_count = stack_full ? count_q : count_q + 1'b1;
    end else if (do_pop && !stack_empty) begin
      upd_tos   = tos_dec;
      upd_top   = entry_q[tos_dec];
      upd_count = count_q - 1'b1;
    end
  end

  // Recovery overrides whatever this fetch group would have done to the stack.
  always_comb begin
    tos_d   = tos_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = tos_inc;
    wr_data = push_addr;
    if (recoverValid) begin
      tos_d   = recoverPtr;
      count_d = recoverCount;
      wr_en   = 1'b1;
      wr_idx  = recoverPtr;
      wr_data = recoverTop;
    end else begin
      tos_d   = upd_tos;
      count_d = upd_count;
      wr_en   = do_push;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tos_q   <= '0;
      count_q <= '0;
    end else begin
      tos_q   <= tos_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      entry_q[wr_idx] <= wr_data;
    end
  end

  assign rasTarget       = entry_q[tos_q];
  assign rasTargetValid  = do_pop && !stack_empty;
  assign rasLane         = do_pop ? active_lane : '0;
  assign checkpointPtr   = upd_tos;
  assign checkpointTop   = upd_top;
  assign checkpointCount = upd_count;
  assign depth           = count_q;

endmodule

// File: tb/tb_return_address_stack.sv
// Directed self-checking bench for return_address_stack with hand-computed expectations.
module tb_return_address_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetchValid;
  logic [31:0] fetchPC;
  logic [1:0]  laneValid;
  logic [1:0]  btbHit;
  logic [1:0]  isRASPushBr;
  logic [1:0]  isRASPopBr;
  logic        rasTargetValid;
  logic [31:0] rasTarget;
  logic [0:0]  rasLane;
  logic [3:0]  checkpointPtr;
  logic [31:0] checkpointTop;
  logic [4:0]  checkpointCount;
  logic        recoverValid;
  logic [3:0]  recoverPtr;
  logic [31:0] recoverTop;
  logic [4:0]  recoverCount;
  logic [4:0]  depth;

  int total = 0;
  int bad   = 0;

  return_address_stack dut (
    .clk            (clk),
    .rst            (rst),
    .fetchValid     (fetchValid),
    .fetchPC        (fetchPC),
    .laneValid      (laneValid),
    .btbHit         (btbHit),
    .isRASPushBr    (isRASPushBr),
    .isRASPopBr     (isRASPopBr),
    .rasTargetValid (rasTargetValid),
    .rasTarget      (rasTarget),
    .rasLane        (rasLane),
    .checkpointPtr  (checkpointPtr),
    .checkpointTop  (checkpointTop),
    .checkpointCount(checkpointCount),
    .recoverValid   (recoverValid),
    .recoverPtr     (recoverPtr),
    .recoverTop     (recoverTop),
    .recoverCount   (recoverCount),
    .depth          (depth)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one fetch group; called just after a falling edge, leaves 1ns for settling.
  task automatic applyStimulus(input logic fv, input logic [31:0] pc, input logic [1:0] lv,
                               input logic [1:0] hit, input logic [1:0] push, input logic [1:0] pop);
    fetchValid  = fv;
    fetchPC     = pc;
    laneValid   = lv;
    btbHit      = hit;
    isRASPushBr = push;
    isRASPopBr  = pop;
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 2'b00, 2'b00, 2'b00, 2'b00);
  endtask

  task automatic pushLane0(input logic [31:0] pc);
    applyStimulus(1'b1, pc, 2'b11, 2'b01, 2'b01, 2'b00);
  endtask

  task automatic popLane0();
    applyStimulus(1'b1, 32'h0, 2'b11, 2'b01, 2'b00, 2'b01);
  endtask

  initial begin
    rst = 1'b1;
    recoverValid = 1'b0;
    recoverPtr   = '0;
    recoverTop   = '0;
    recoverCount = '0;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle();
    checkOutput("resetDepth", 64'(depth), 64'd0);
    checkOutput("resetCkptCount", 64'(checkpointCount), 64'd0);
    checkOutput("resetValid", 64'(rasTargetValid), 64'd0);

    // Pop on an empty stack
    @(negedge clk);
    popLane0();
    checkOutput("emptyPopValid", 64'(rasTargetValid), 64'd0);
    checkOutput("emptyPopPtr", 64'(checkpointPtr), 64'd0);
    checkOutput("emptyPopCount", 64'(checkpointCount), 64'd0);
    @(negedge clk);
    idle();
    checkOutput("emptyPopDepth", 64'(depth), 64'd0);

    // Lane-1 call then lane-0 return
    @(negedge clk);
    applyStimulus(1'b1, 32'h1000, 2'b11, 2'b10, 2'b10, 2'b00);
    checkOutput("pushL1CkptTop", 64'(checkpointTop), 64'h1008);
    checkOutput("pushL1CkptPtr", 64'(checkpointPtr), 64'd1);
    checkOutput("pushL1Valid", 64'(rasTargetValid), 64'd0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 2'b11, 2'b01, 2'b00, 2'b01);
    checkOutput("noFetchValid", 64'(rasTargetValid), 64'd0);
    checkOutput("noFetchCount", 64'(checkpointCount), 64'd1);
    @(negedge clk);
    popLane0();
    checkOutput("popL0Target", 64'(rasTarget), 64'h1008);
    checkOutput("popL0Lane", 64'(rasLane), 64'd0);
    checkOutput("popL0Valid", 64'(rasTargetValid), 64'd1);
    checkOutput("popL0CkptCount", 64'(checkpointCount), 64'd0);
    @(negedge clk);
    idle();
    checkOutput("popL0Depth", 64'(depth), 64'd0);

    // Overflow: 17 calls wrap over the oldest entry
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      pushLane0(32'(k * 256));
      if (k == 17) checkOutput("fullCkptCount", 64'(checkpointCount), 64'd16);
    end
    @(negedge clk);
    idle();
    checkOutput("fullDepth", 64'(depth), 64'd16);
    for (int k = 17; k >= 2; k--) begin
      @(negedge clk);
      popLane0();
      checkOutput("lifoTarget", 64'(rasTarget), 64'(k * 256 + 4));
      checkOutput("lifoValid", 64'(rasTargetValid), 64'd1);
    end
    @(negedge clk);
    popLane0();
    checkOutput("underflowValid", 64'(rasTargetValid), 64'd0);
    @(negedge clk);
    idle();
    checkOutput("drainedDepth", 64'(depth), 64'd0);

    // Lane-0 call hides a lane-1 return
    @(negedge clk);
    applyStimulus(1'b1, 32'h2000, 2'b11, 2'b11, 2'b01, 2'b10);
    checkOutput("mixValid", 64'(rasTargetValid), 64'd0);
    checkOutput("mixCkptTop", 64'(checkpointTop), 64'h2004);
    checkOutput("mixCkptCount", 64'(checkpointCount), 64'd1);
    @(negedge clk);
    idle();
    checkOutput("mixDepth", 64'(depth), 64'd1);

    // Build a known checkpoint from a clean stack
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pushLane0(32'h10);
    @(negedge clk);
    pushLane0(32'h20);
    @(negedge clk);
    pushLane0(32'h3C);
    checkOutput("ckptPtr", 64'(checkpointPtr), 64'd3);
    checkOutput("ckptTop", 64'(checkpointTop), 64'h40);
    checkOutput("ckptCount", 64'(checkpointCount), 64'd3);
    @(negedge clk);
    pushLane0(32'h500);
    @(negedge clk);
    pushLane0(32'h600);
    @(negedge clk);
    recoverValid = 1'b1;
    recoverPtr   = 4'd3;
    recoverTop   = 32'h40;
    recoverCount = 5'd3;
    pushLane0(32'h700);
    @(negedge clk);
    recoverValid = 1'b0;
    idle();
    checkOutput("recoverDepth", 64'(depth), 64'd3);
    @(negedge clk);
    popLane0();
    checkOutput("recoverPopTarget", 64'(rasTarget), 64'h40);
    checkOutput("recoverPopValid", 64'(rasTargetValid), 64'd1);
    @(negedge clk);
    popLane0();
    checkOutput("recoverPop2Target", 64'(rasTarget), 64'h24);

    // Reset beats a concurrent push
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pushLane0(32'h8000 + 32'(k * 16));
    end
    @(negedge clk);
    idle();
    checkOutput("preResetDepth", 64'(depth), 64'd5);
    @(negedge clk);
    rst = 1'b1;
    pushLane0(32'h9000);
    @(negedge clk);
    rst = 1'b0;
    idle();
    checkOutput("midResetDepth", 64'(depth), 64'd0);
    @(negedge clk);
    popLane0();
    checkOutput("midResetPopValid", 64'(rasTargetValid), 64'd0);
    @(negedge clk);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/return_address_stack.md
Name: return_address_stack

Overview:
- Speculative return address stack (RAS) on the fetch side, consuming the per-lane BTB lookup results (hit, RAS-push, RAS-pop flags).
- Pushes the return address for call-type branches and supplies the predicted target for return-type branches to next-PC selection in the same cycle.
- Emits a per-fetch-group checkpoint that travels down the pipeline and is fed back on branch-mispredict recovery.

Parameters:
FETCH_WIDTH, 2, fetch lanes per group
RAS_ENTRY_NUM, 16, stack entries (power of two)
PC_WIDTH, 32, PC width in bits
INSN_BYTE_WIDTH, 4, instruction size in bytes
PTR_WIDTH, $clog2(RAS_ENTRY_NUM), derived stack pointer width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetchValid  in  1  fetch group valid and advancing this cycle
fetchPC  in  PC_WIDTH  PC of lane 0
laneValid  in  FETCH_WIDTH  lane holds a valid instruction
btbHit  in  FETCH_WIDTH  BTB hit per lane
isRASPushBr  in  FETCH_WIDTH  BTB entry is a call
isRASPopBr  in  FETCH_WIDTH  BTB entry is a return
rasTargetValid  out  1  rasTarget is a usable prediction
rasTarget  out  PC_WIDTH  predicted return target
rasLane  out  max(1,$clog2(FETCH_WIDTH))  lane the prediction applies to
checkpointPtr  out  PTR_WIDTH  top-of-stack pointer after this group's update
checkpointTop  out  PC_WIDTH  top entry value after this group's update
checkpointCount  out  PTR_WIDTH+1  valid-entry count after this group's update
recoverValid  in  1  restore from checkpoint
recoverPtr  in  PTR_WIDTH  restored pointer
recoverTop  in  PC_WIDTH  restored top entry value
recoverCount  in  PTR_WIDTH+1  restored count
depth  out  PTR_WIDTH+1  current valid-entry count

Behaviour:
- State: entry array [RAS_ENTRY_NUM] x PC_WIDTH, tos pointer (index of the top valid entry), count.
- Reset: tos=0, count=0; entries not cleared. All outputs follow from state: depth=0, rasTargetValid=0, checkpointCount=0.
- Lane select:
  - Active lane = lowest i with laneValid[i] && btbHit[i], only when fetchValid=1.
  - A BTB hit is always a taken branch, so younger lanes are ignored.
  - If no lane is active: no operation; rasTargetValid=0, rasLane=0.
- Push (active lane has isRASPushBr):
  - Next cycle: tos<=tos+1 mod N; entry[tos+1]<=fetchPC+(i+1)*INSN_BYTE_WIDTH; count<=min(count+1,N).
  - Full stack: wrap overwrites the oldest entry; count stays N.
- Pop (active lane has isRASPopBr, push flag clear):
  - Same cycle: rasTarget=entry[tos], rasLane=i, rasTargetValid=(count!=0).
  - Next cycle if count!=0: tos<=tos-1 mod N, count<=count-1.
  - count==0: rasTargetValid=0, state unchanged.
- Both flags set on one lane: treated as push only.
- Prediction latency 0 cycles (combinational read of entry[tos]); updates visible the following cycle. PC arithmetic is modulo 2^PC_WIDTH.
- rasTarget when rasTargetValid=0: entry[tos]. Value don't-care.
- Checkpoint outputs (combinational, same cycle as fetch) = post-update {tos, entry[tos], count}. checkpointTop equals the pushed address on a push and entry[tos-1] on a pop. No op: current state.
- Recovery: recoverValid=1 → next cycle tos<=recoverPtr, entry[recoverPtr]<=recoverTop, count<=recoverCount.
  - Any fetch update in the same cycle is dropped.
  - rasTarget/rasTargetValid that cycle still reflect pre-recovery state; consumer discards them.
- rst has priority over recoverValid and fetch updates.
- No handshake stall: the block accepts every fetchValid cycle.

Test Plan:
- Reset for 1 cycle, then fetch pop on lane 0 → depth=0, rasTargetValid=0, tos unchanged.
- fetchPC=0x1000 with push hit on lane 1; next cycle pop hit on lane 0 → rasTarget=0x1008, rasLane=0, rasTargetValid=1; following cycle depth=0.
- 17 pushes of lane-0 calls at PCs 0x100,0x200,...,0x1100 → depth=16; 16 pops return 0x1104 down to 0x204 in LIFO order; 17th pop has rasTargetValid=0.
- Lane 0 push hit (PC 0x2000) and lane 1 pop hit in one group → only push applied, rasTargetValid=0, checkpointTop=0x2004, depth +1.
- Capture checkpoint (ptr=3, top=0x40, count=3); then 2 pushes; then recoverValid concurrent with a push → next cycle depth=3, pop returns 0x40, concurrent push absent.
- Assert rst mid-sequence with depth=5 and a concurrent push → next cycle depth=0, pop gives rasTargetValid=0.
